// File: rtl/riscv_fetch_buffer.sv
// Instruction prefetch buffer in front of the multi-cycle RISC-V core.
//
// Streams sequential word fetches from instruction memory (one outstanding
// req/ack transaction at a time) into a circular FIFO of {addr, instr}
// entries. The head entry is presented to the core when its address matches
// core_pc_i. Any request for an address other than the current stream
// address flushes the FIFO and restarts fetching from core_pc_i. A response
// that was already in flight when the redirect happened is absorbed and
// dropped.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   core_pc_i     word address the core wants
//   core_req_i    core requests the instruction at core_pc_i this cycle
//   core_instr_o  instruction for core_pc_i, 0 when core_valid_o is low
//   core_valid_o  core_instr_o valid; the head entry is popped this cycle
//   imem_req_o    memory request, held until imem_ack_i
//   imem_addr_o   memory request word address, stable while imem_req_o is high
//   imem_ack_i    request accepted, imem_rdata_i valid this cycle
//   imem_rdata_i  fetched instruction word
module riscv_fetch_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_pc_i,
  input  logic              core_req_i,
  output logic [31:0]       core_instr_o,
  output logic              core_valid_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0]   DepthCnt = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [PtrW-1:0]   PtrOne   = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e            state_q;
  logic              imem_req_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];

  logic [ADDR_W-1:0] head_addr;
  logic [ADDR_W-1:0] stream_addr;
  logic              fifo_nonempty;
  logic              hit;
  logic              redirect;
  logic              push;
  logic              pop;
  logic [CntW-1:0]   count_next;

  assign head_addr     = addr_mem_q[rd_ptr_q];
  assign fifo_nonempty = (count_q != '0);

  // The address the core is expected to ask for next if the stream is intact.
  always_comb begin
    stream_addr = fetch_addr_q;
    if (fifo_nonempty) begin
      stream_addr = head_addr;
    end else if (state_q == StReq) begin
      stream_addr = imem_addr_q;
    end
  end

  // hit and redirect are mutually exclusive: a hit implies core_pc_i equals
  // the head address, which is the stream address whenever the FIFO is non-empty.
  assign hit        = core_req_i && fifo_nonempty && (head_addr == core_pc_i);
  assign redirect   = core_req_i && (core_pc_i != stream_addr);
  assign pop        = hit;
  assign push       = (state_q == StReq) && imem_ack_i && !redirect;
  assign count_next = count_q + CntW'(push) - CntW'(pop);

  assign core_valid_o = hit;
  assign core_instr_o = hit ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = imem_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      fetch_addr_q <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      if (push) begin
        addr_mem_q[wr_ptr_q]  <= imem_addr_q;
        instr_mem_q[wr_ptr_q] <= imem_rdata_i;
        wr_ptr_q              <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end

      if (redirect) begin
        count_q      <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        fetch_addr_q <= core_pc_i;
      end else begin
        count_q <= count_next;
      end

      case (state_q)
        StIdle: begin
          if (!redirect && (count_q < DepthCnt)) begin
            imem_req_q   <= 1'b1;
            imem_addr_q  <= fetch_addr_q;
            fetch_addr_q <= fetch_addr_q + AddrOne;
            state_q      <= StReq;
          end
        end
        StReq: begin
          if (imem_ack_i) begin
            if (!redirect && (count_next < DepthCnt)) begin
              // Back-to-back: launch the next sequential fetch immediately.
              imem_addr_q  <= fetch_addr_q;
              fetch_addr_q <= fetch_addr_q + AddrOne;
            end else begin
              imem_req_q <= 1'b0;
              state_q    <= StIdle;
            end
          end else if (redirect) begin
            // The request cannot be withdrawn; wait for its stale response.
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (imem_ack_i) begin
            imem_req_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Self-checking bench for riscv_fetch_buffer. A memory model answers each
// request after a programmable number of wait cycles with 0x13 + addr.
module tb_riscv_fetch_buffer;

  localparam int unsigned AW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] core_pc;
  logic          core_req;
  logic [31:0]   core_instr;
  logic          core_valid;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   exp_q[$];
  logic [AW-1:0] ack_log[$];
  int unsigned   mem_wait = 0;
  int unsigned   wcnt = 0;

  riscv_fetch_buffer #(
    .DEPTH (4),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_pc_i   (core_pc),
    .core_req_i  (core_req),
    .core_instr_o(core_instr),
    .core_valid_o(core_valid),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_rdata_i(imem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: one-cycle ack pulse after mem_wait idle cycles of a held request.
  always @(posedge clk) begin
    if (rst) begin
      imem_ack <= 1'b0;
      wcnt     <= 0;
    end else if (imem_ack) begin
      imem_ack <= 1'b0;
    end else if (imem_req) begin
      if (wcnt < mem_wait) begin
        wcnt <= wcnt + 1;
      end else begin
        imem_ack   <= 1'b1;
        imem_rdata <= 32'h13 + {2'b00, imem_addr};
        wcnt       <= 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && imem_ack) ack_log.push_back(imem_addr);
  end

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   exp_instr;
    bit            idle_first;  // drop core_req and let the buffer fill first
    int            lat;         // exact sample index of valid; -1 any; -2 not immediate
    int            exp_acks;    // acks logged before applying; -1 unchecked
    int            nxt;         // imem_addr expected one cycle after the pop; -1 unchecked
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < 0 || i >= ack_log.size()) return 32'hDEAD_BEEF;
    return {2'b00, ack_log[i]};
  endfunction

  // Request pc, wait (bounded) for the hit, compare against the scoreboard.
  task automatic fetch(input logic [AW-1:0] pc, input logic [31:0] exp, input int lat);
    int idx;
    logic [31:0] want;
    exp_q.push_back(exp);
    core_req = 1'b1;
    core_pc  = pc;
    idx = 0;
    forever begin
      @(negedge clk);
      if (core_valid || idx >= 60) break;
      idx++;
    end
    want = exp_q.pop_front();
    check($sformatf("valid pc=%08h", pc), {31'b0, core_valid}, 32'h1);
    if (core_valid) begin
      check($sformatf("instr pc=%08h", pc), core_instr, want);
      if (lat >= 0) check($sformatf("latency pc=%08h", pc), idx, lat);
      else if (lat == -2) check($sformatf("not immediate pc=%08h", pc), {31'b0, idx != 0}, 32'h1);
    end
    @(posedge clk);
    #1;
    core_req = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!imem_req && k < 40);
    check(name, {31'b0, imem_req}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int idx;

    tbl[0] = '{30'h0,        32'h13,       1'b0, -1, -1, -1};
    tbl[1] = '{30'h1,        32'h14,       1'b0, -1, -1, -1};
    tbl[2] = '{30'h2,        32'h15,       1'b0, -1, -1, -1};
    tbl[3] = '{30'h3,        32'h16,       1'b0, -1, -1, -1};
    tbl[4] = '{30'h4,        32'h17,       1'b1,  0,  8,  8};
    tbl[5] = '{30'h100,      32'h113,      1'b0, -2, -1, -1};
    tbl[6] = '{30'h101,      32'h114,      1'b0, -1, -1, -1};
    tbl[7] = '{30'h3FFFFFFF, 32'h40000012, 1'b1,  4, -1, -1};
    tbl[8] = '{30'h0,        32'h13,       1'b0, -1, -1, -1};
    tbl[9] = '{30'h1,        32'h14,       1'b0, -1, -1, -1};

    // Reset state; core_req asserted to show it cannot produce a hit.
    rst      = 1'b1;
    core_req = 1'b1;
    core_pc  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset imem_req", {31'b0, imem_req}, 32'h0);
    check("reset imem_addr", {2'b00, imem_addr}, 32'h0);
    check("reset core_valid", {31'b0, core_valid}, 32'h0);
    check("reset core_instr", core_instr, 32'h0);
    core_req = 1'b0;
    rst      = 1'b0;

    // Sequential stream, full buffer, redirect, wrap-around.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].idle_first) begin
        core_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check($sformatf("vec%0d idle imem_req", i), {31'b0, imem_req}, 32'h0);
        if (tbl[i].exp_acks >= 0)
          check($sformatf("vec%0d pushes", i), ack_log.size(), tbl[i].exp_acks);
      end
      fetch(tbl[i].pc, tbl[i].exp_instr, tbl[i].lat);
      if (tbl[i].nxt >= 0) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d next req", i), {31'b0, imem_req}, 32'h1);
        check($sformatf("vec%0d next addr", i), {2'b00, imem_addr}, tbl[i].nxt);
      end
    end

    for (int i = 0; i < 4; i++) check($sformatf("seq addr %0d", i), log_at(i), i);
    idx = -1;
    for (int i = 0; i < ack_log.size(); i++) if (idx < 0 && ack_log[i] == 30'h100) idx = i;
    check("stale ack before 0x100", log_at(idx - 1), 32'h8);
    idx = -1;
    for (int i = 0; i < ack_log.size(); i++) if (idx < 0 && ack_log[i] == 30'h3FFFFFFF) idx = i;
    check("wrap found", {31'b0, idx >= 0}, 32'h1);
    check("wrap next addr", log_at(idx + 1), 32'h0);

    // Redirect while a slow request is in flight: address held, data dropped.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_wait = 3;
    base     = ack_log.size();
    wait_req("inflight req");
    @(posedge clk);
    #1;
    core_req = 1'b1;
    core_pc  = 30'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("drop held req %0d", i), {31'b0, imem_req}, 32'h1);
      check($sformatf("drop held addr %0d", i), {2'b00, imem_addr}, 32'h0);
      check($sformatf("drop no valid %0d", i), {31'b0, core_valid}, 32'h0);
    end
    fetch(30'h200, 32'h213, -1);
    check("drop stale ack addr", log_at(base), 32'h0);
    check("drop next addr", log_at(base + 1), 32'h200);

    // Reset in the middle of a request.
    wait_req("pre-reset req");
    @(posedge clk);
    #1;
    rst      = 1'b1;
    core_req = 1'b1;
    core_pc  = 30'h202;
    @(posedge clk);
    #1;
    check("midreset imem_req", {31'b0, imem_req}, 32'h0);
    check("midreset imem_addr", {2'b00, imem_addr}, 32'h0);
    check("midreset core_valid", {31'b0, core_valid}, 32'h0);
    rst      = 1'b0;
    core_req = 1'b0;
    mem_wait = 0;
    wait_req("post-reset req");
    check("post-reset addr", {2'b00, imem_addr}, 32'h0);
    fetch(30'h0, 32'h13, -1);

    check("scoreboard empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
